// File: rtl/wb_serial_pkg.sv
// wb_serial_pkg: shared constants for the Wishbone serial transmitter.
// Register map indices, CTRL/STATUS field layout, and the transmit FSM states.
package wb_serial_pkg;

    localparam int FRAME_W_DEFAULT = 10;

    // Register indices decoded from ADR_I[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_TXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // CTRL fields
    localparam int CTRL_DIV_LSB = 0;
    localparam int CTRL_DIV_W   = 8;
    localparam int CTRL_GAP_LSB = 8;
    localparam int CTRL_GAP_W   = 8;
    localparam int CTRL_EN_BIT  = 16;
    localparam int CTRL_MSB_BIT = 17;
    localparam int CTRL_ODD_BIT = 18;

    // STATUS fields
    localparam int ST_BUSY_BIT = 0;
    localparam int ST_FULL_BIT = 1;
    localparam int ST_CNT_LSB  = 8;
    localparam int ST_CNT_W    = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_SHIFT,
        TX_GAP
    } tx_state_e;

endpackage

// File: rtl/wb_serial_tx_if.sv
// wb_serial_tx_if: Wishbone classic single-beat bus between initiator and
// the serial transmitter. Signal names follow the responder's view.
interface wb_serial_tx_if;
    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic [31:0] ADR_I;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK_O;

    modport master (output CYC_I, STB_I, WE_I, ADR_I, DAT_I,
                    input  DAT_O, ACK_O);
    modport slave  (input  CYC_I, STB_I, WE_I, ADR_I, DAT_I,
                    output DAT_O, ACK_O);
endinterface

// File: rtl/wb_serial_baud_tick.sv
// wb_serial_baud_tick: bit-period down-counter. Pulses tick once every
// div+1 cycles; restart reloads the count so a new period begins next cycle.
module wb_serial_baud_tick (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic [7:0] div,
    output logic       tick,
    output logic [7:0] cnt
);
    logic [7:0] r_cnt;

    // Count down to zero, reload on expiry or on an explicit restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= 8'd0;
        else if (restart || r_cnt == 8'd0)
            r_cnt <= div;
        else
            r_cnt <= r_cnt - 8'd1;
    end

    assign tick = (r_cnt == 8'd0) && !restart;
    assign cnt  = r_cnt;
endmodule

// File: rtl/wb_serial_tx.sv
// wb_serial_tx: Wishbone responder feeding a framed serial transmitter with
// a one-entry holding register in front of the shifter.
// Optional feature macro: WB_SERIAL_TX_PARITY_EN appends a parity bit to each
// frame and makes CTRL[18] (odd parity select) writable.
module wb_serial_tx
    import wb_serial_pkg::*;
#(
    parameter int         FRAME_W = FRAME_W_DEFAULT,
    parameter logic [7:0] DIV_RST = 8'd0,
    parameter logic [7:0] GAP_RST = 8'd1
) (
    input  logic          CLK_I,
    input  logic          RST_NI,
    wb_serial_tx_if.slave wb,
    output logic          data_o,
    output logic          ena_o,
    output logic          busy_o
);
`ifdef WB_SERIAL_TX_PARITY_EN
    localparam int SH_W = FRAME_W + 1;
`else
    localparam int SH_W = FRAME_W;
`endif
    localparam int BCW = $clog2(SH_W + 1);

    // CTRL register and its shadow copies used by the frame in flight
    logic [7:0]         r_div, r_gap, r_div_s, r_gap_s;
    logic               r_en, r_msb, r_msb_s;
    logic               w_odd;
    // Holding register and bus response
    logic [FRAME_W-1:0] r_hold;
    logic               r_full, r_ack;
    logic [31:0]        r_dat, w_rdata;
    // Transmit path
    tx_state_e          r_state;
    logic [SH_W-1:0]    r_sh, w_frame;
    logic [BCW-1:0]     r_bits;
    logic [7:0]         r_gcnt, r_sent, w_cnt, w_tick_div;
    logic               r_data, r_ena, w_tick, w_restart, w_ovl, w_busy;
    logic               w_req, w_stall, w_acc;
    logic [1:0]         w_idx;
    logic               w_unused;

`ifdef WB_SERIAL_TX_PARITY_EN
    logic r_odd;
    logic w_par;
    assign w_odd   = r_odd;
    assign w_par   = (^r_hold) ^ r_odd;
    // Parity always trails the payload, whichever end is sent first
    assign w_frame = r_msb ? {r_hold, w_par} : {w_par, r_hold};
`else
    assign w_odd   = 1'b0;
    assign w_frame = r_hold;
`endif

    assign w_busy   = (r_state != TX_IDLE) || r_full;
    assign w_idx    = wb.ADR_I[3:2];
    assign w_req    = wb.CYC_I && wb.STB_I && !r_ack;
    assign w_stall  = wb.WE_I && (w_idx == REG_TXDATA) && r_full;
    assign w_acc    = w_req && !w_stall;
    assign w_unused = ^{wb.ADR_I[31:4], wb.ADR_I[1:0], wb.DAT_I};

    // Bit timer restarts on LOAD using the CTRL value about to become the shadow
    assign w_restart  = (r_state == TX_LOAD);
    assign w_tick_div = w_restart ? r_div : r_div_s;

    wb_serial_baud_tick u_tick (
        .clk     (CLK_I),
        .rst_n   (RST_NI),
        .restart (w_restart),
        .div     (w_tick_div),
        .tick    (w_tick),
        .cnt     (w_cnt)
    );

    // With GAP=0 and a word waiting, enter LOAD during the final cycle of the
    // last bit so the next frame starts with no idle cycle on ena_o.
    assign w_ovl = (r_state == TX_SHIFT) && r_en && r_full && (r_gap_s == 8'd0) &&
                   (((r_bits == BCW'(1)) && (w_cnt == 8'd1)) ||
                    ((r_bits == BCW'(2)) && w_tick && (r_div_s == 8'd0)));

    // Read data mux, sampled into DAT_O on the ACK edge
    always_comb begin
        w_rdata = 32'd0;
        case (w_idx)
            REG_CTRL:   w_rdata = {13'd0, w_odd, r_msb, r_en, r_gap, r_div};
            REG_TXDATA: w_rdata = {{(32-FRAME_W){1'b0}}, r_hold};
            REG_STATUS: w_rdata = {16'd0, r_sent, 6'd0, r_full, w_busy};
            default:    w_rdata = 32'd0;
        endcase
    end

    // Bus side: single-cycle ACK, register writes, holding-register fill/drain
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_ack  <= 1'b0;
            r_dat  <= 32'd0;
            r_div  <= DIV_RST;
            r_gap  <= GAP_RST;
            r_en   <= 1'b0;
            r_msb  <= 1'b0;
`ifdef WB_SERIAL_TX_PARITY_EN
            r_odd  <= 1'b0;
`endif
            r_hold <= '0;
            r_full <= 1'b0;
        end else begin
            r_ack <= w_acc;
            r_dat <= (w_acc && !wb.WE_I) ? w_rdata : 32'd0;
            if (r_state == TX_LOAD)
                r_full <= 1'b0;
            if (w_acc && wb.WE_I) begin
                case (w_idx)
                    REG_CTRL: begin
                        r_div <= wb.DAT_I[CTRL_DIV_LSB +: CTRL_DIV_W];
                        r_gap <= wb.DAT_I[CTRL_GAP_LSB +: CTRL_GAP_W];
                        r_en  <= wb.DAT_I[CTRL_EN_BIT];
                        r_msb <= wb.DAT_I[CTRL_MSB_BIT];
`ifdef WB_SERIAL_TX_PARITY_EN
                        r_odd <= wb.DAT_I[CTRL_ODD_BIT];
`endif
                    end
                    REG_TXDATA: begin
                        r_hold <= wb.DAT_I[FRAME_W-1:0];
                        r_full <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Transmit FSM: IDLE -> LOAD -> SHIFT -> (GAP) -> IDLE, outputs registered
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_state <= TX_IDLE;
            r_sh    <= '0;
            r_bits  <= '0;
            r_gcnt  <= 8'd0;
            r_div_s <= DIV_RST;
            r_gap_s <= GAP_RST;
            r_msb_s <= 1'b0;
            r_sent  <= 8'd0;
            r_data  <= 1'b0;
            r_ena   <= 1'b0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (r_en && r_full)
                        r_state <= TX_LOAD;
                end
                TX_LOAD: begin
                    // ena_o already high means this LOAD overlapped a frame's last bit
                    if (r_ena)
                        r_sent <= r_sent + 8'd1;
                    r_sh    <= r_msb ? (w_frame << 1) : (w_frame >> 1);
                    r_data  <= r_msb ? w_frame[SH_W-1] : w_frame[0];
                    r_ena   <= 1'b1;
                    r_bits  <= BCW'(SH_W);
                    r_div_s <= r_div;
                    r_gap_s <= r_gap;
                    r_msb_s <= r_msb;
                    r_state <= TX_SHIFT;
                end
                TX_SHIFT: begin
                    if (w_tick) begin
                        if (r_bits == BCW'(1)) begin
                            r_sent  <= r_sent + 8'd1;
                            r_ena   <= 1'b0;
                            r_data  <= 1'b0;
                            r_gcnt  <= r_gap_s;
                            r_state <= (r_gap_s == 8'd0) ? TX_IDLE : TX_GAP;
                        end else begin
                            r_data <= r_msb_s ? r_sh[SH_W-1] : r_sh[0];
                            r_sh   <= r_msb_s ? (r_sh << 1) : (r_sh >> 1);
                            r_bits <= r_bits - BCW'(1);
                        end
                    end
                    if (w_ovl)
                        r_state <= TX_LOAD;
                end
                TX_GAP: begin
                    if (w_tick) begin
                        if (r_gcnt == 8'd1)
                            r_state <= TX_IDLE;
                        else
                            r_gcnt <= r_gcnt - 8'd1;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign wb.ACK_O = r_ack;
    assign wb.DAT_O = r_dat;
    assign data_o   = r_data;
    assign ena_o    = r_ena;
    assign busy_o   = w_busy;
endmodule

// File: doc/wb_serial_tx.md
# wb_serial_tx

Wishbone classic-cycle responder that accepts configuration and data words from a bus initiator and serializes 10-bit frames onto a `data_o`/`ena_o` pair. The bus side is the slave end of the single-beat write/read handshake that the system testbench and the SoC bus master drive. The line side is a framed serial transmitter with programmable bit period and inter-frame gap. A one-entry holding register double-buffers the shifter, so the initiator can queue the next frame while the current one shifts.

## Interface
- `FRAME_W`, 10: payload bits per frame.
- `DIV_RST`, 8'd0: reset value of CTRL.DIV.
- `GAP_RST`, 8'd1: reset value of CTRL.GAP.
- `CLK_I` in 1: single clock; all logic is on the rising edge.
- `RST_NI` in 1: asynchronous, active-low reset.
- `CYC_I` in 1: bus cycle valid.
- `STB_I` in 1: strobe.
- `WE_I` in 1: 1 = write.
- `ADR_I` in 32: byte address; only `[3:2]` is decoded.
- `DAT_I` in 32: write data.
- `DAT_O` out 32: read data, valid while `ACK_O`=1.
- `ACK_O` out 1: single-cycle acknowledge.
- `data_o` out 1: serial bit.
- `ena_o` out 1: high while frame bits are driven.
- `busy_o` out 1: shifter or holding register occupied.

## Operation
- Registers (`ADR_I[3:2]`):
  - 0 = CTRL (RW): `[7:0]` DIV, cycles per bit − 1; `[15:8]` GAP, idle bit-periods between frames; `[16]` EN; `[17]` MSB_FIRST.
  - 1 = TXDATA (W: `[FRAME_W-1:0]` loads the holding register; R: current holding contents).
  - 2 = STATUS (R): `[0]` busy, `[1]` hold_full, `[15:8]` frames-sent counter (8-bit, wraps 255→0).
  - 3: reads 0, writes ignored, still acknowledged.
- Writes to read-only fields are ignored.
- Transmit FSM states: IDLE, LOAD, SHIFT, GAP.
  - IDLE→LOAD when EN=1 and hold_full=1.
  - LOAD (1 cycle): the holding register moves to the shifter, DIV/GAP/MSB_FIRST are latched into shadow copies, and hold_full clears.
  - SHIFT: each bit is driven for DIV+1 cycles. After the last bit the counter increments and the FSM goes to GAP, or to IDLE when GAP=0.
  - GAP: `ena_o`=0 for GAP×(DIV+1) cycles, then IDLE.
- Clearing EN mid-frame lets the current frame and its gap complete. No new LOAD occurs until EN is set again.
- CTRL writes during a frame affect only the next LOAD.

## Timing
- Reset values:
  - `ACK_O`=0, `DAT_O`=0, `data_o`=0, `ena_o`=0, `busy_o`=0.
  - CTRL = {MSB_FIRST=0, EN=0, GAP_RST, DIV_RST}; counter 0; hold empty; FSM in IDLE.
- Asserting `RST_NI` mid-frame forces all of these values immediately, without waiting for a clock edge.
- `ACK_O` is registered. It rises the cycle after `CYC_I&STB_I` is sampled high with `ACK_O`=0, lasts exactly one cycle, and is not reasserted until the master drops STB or presents a new cycle. Back-to-back cycles therefore see at most one ACK every 2 cycles.
- A TXDATA write while hold_full=1 is stalled: ACK is withheld until the cycle after LOAD empties the holding register. The initiator must hold CYC/STB/ADR/DAT stable during the stall.
- The register write and the hold_full set happen on the ACK edge T.
- With the FSM in IDLE and EN=1: LOAD occurs at T+1, and `ena_o`=1 with the first bit at T+2.
- `data_o` is held at 0 whenever `ena_o`=0.
- With GAP=0, `ena_o` stays high across back-to-back frames, with no idle cycle when the next LOAD is pending. LOAD overlaps the last bit-cycle in this case.
- STATUS reads return values sampled on the ACK edge.

## Configuration
- `WB_SERIAL_TX_PARITY_EN` defined:
  - An even-parity bit is appended after the payload, so a frame is FRAME_W+1 bits and `ena_o` is high (FRAME_W+1)×(DIV+1) cycles.
  - CTRL`[18]` selects odd parity.
- `WB_SERIAL_TX_PARITY_EN` undefined: no parity bit, and CTRL`[18]` reads 0.

## Structure
- Package `wb_serial_pkg` holds:
  - register-index constants;
  - CTRL/STATUS field positions and widths;
  - the FSM state enum `tx_state_e`;
  - `FRAME_W` default.
- Sub-module `wb_serial_baud_tick` holds the DIV down-counter. It takes inputs `restart` and `div[7:0]` and pulses a `tick` every DIV+1 cycles. The top-level FSM uses `tick` to advance bits and gap periods.

## Test plan
- CTRL write, reset, and read-back:
  - Release `RST_NI`, then write CTRL=0x30201 -> ACK one cycle after STB.
  - Read CTRL -> 0x00030201.
  - Read STATUS -> 0.
- MSB-first frame:
  - With CTRL=0x30201, write TXDATA=0x2A5 -> `ena_o` high 20 cycles starting 2 cycles after ACK.
  - `data_o` sequence 1,0,1,0,1,0,0,1,0,1, each bit held 2 cycles.
  - `ena_o` then low 4 cycles.
  - STATUS`[15:8]`=1.
- Stall on full holding register:
  - Write three TXDATA words back-to-back -> first two ACK promptly.
  - Third ACK is withheld until the second frame's LOAD.
  - All three frames appear in order.
- GAP=0, LSB-first:
  - CTRL=0x10000, two queued writes 0x001, 0x3FF -> `ena_o` continuous for 20 cycles.
  - Bits 1,0×9,1×10.
- Reset mid-frame:
  - Drive `RST_NI` low in the 5th bit -> `ena_o`, `data_o`, `busy_o`, `ACK_O` are 0 immediately.
  - CTRL reads 0x00000100.
- Counter wrap and unmapped address:
  - Send 256 frames -> counter reads 0.
  - Write to `ADR_I`=0xC -> ACK given, subsequent read returns 0.
